// File: rtl/bsg_bitwise_reduce_pipe_if.sv
// Handshake bundle for bsg_bitwise_reduce_pipe: valid/ready input side,
// valid/yumi output side. The producer/consumer bench side uses master, the block uses slave.
interface bsg_bitwise_reduce_pipe_if #(
   parameter int width_p = 16,
   parameter int els_p   = 3
);
   logic                       v_i;
   logic [els_p*width_p-1:0]   data_i;
   logic [2:0]                 op_i;
   logic                       ready_o;
   logic                       v_o;
   logic [width_p-1:0]         data_o;
   logic                       yumi_i;

   modport master (
      output v_i, data_i, op_i, yumi_i,
      input  ready_o, v_o, data_o
   );

   modport slave (
      input  v_i, data_i, op_i, yumi_i,
      output ready_o, v_o, data_o
   );
endinterface

// File: rtl/bsg_bitwise_reduce_pipe.sv
// Bitwise reduction (OR/NOR/AND/NAND/XOR/XNOR) across els_p operands,
// registered into a 2-entry output FIFO with valid/ready in, valid/yumi out.
// Op codes 6 and 7 fall back to NOR so a legacy 3-input NOR user sees no change.
module bsg_bitwise_reduce_pipe #(
   parameter int width_p = 16,
   parameter int els_p   = 3
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   bsg_bitwise_reduce_pipe_if.slave  io
);

   logic [width_p-1:0] red_or, red_and, red_xor;
   logic [width_p-1:0] result_d;
   logic [width_p-1:0] mem_q [2];
   logic               rd_ptr_q, wr_ptr_q;
   logic               rd_ptr_d, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               accept, pop;

   // Per-bit reductions across all operands, then select by op.
   always_comb begin
      red_or  = '0;
      red_and = '1;
      red_xor = '0;
      for (int k = 0; k < els_p; k++) begin
         red_or  = red_or  | io.data_i[k*width_p +: width_p];
         red_and = red_and & io.data_i[k*width_p +: width_p];
         red_xor = red_xor ^ io.data_i[k*width_p +: width_p];
      end
      case (io.op_i)
         3'd0:    result_d = red_or;
         3'd2:    result_d = red_and;
         3'd3:    result_d = ~red_and;
         3'd4:    result_d = red_xor;
         3'd5:    result_d = ~red_xor;
         default: result_d = ~red_or;
      endcase
   end

   // ready depends only on registered occupancy; reset forces it low at once.
   assign io.ready_o = ~reset_i & (count_q != 2'd2);
   assign io.v_o     = (count_q != 2'd0);
   assign io.data_o  = mem_q[rd_ptr_q];

   // A yumi with nothing buffered is ignored rather than corrupting occupancy.
   assign accept = io.v_i & io.ready_o;
   assign pop    = io.yumi_i & io.v_o;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = accept ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop    ? ~rd_ptr_q : rd_ptr_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage and pointers; reset clears storage so data_o reads zero.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (accept) mem_q[wr_ptr_q] <= result_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Consumer must not take data that is not there.
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(io.yumi_i && !io.v_o));

endmodule

// File: tb/tb_bsg_bitwise_reduce_pipe.sv
// Drives three instances (els_p = 1, 3, 8) with one shared stimulus stream.
// Handshake behaviour does not depend on data, so a single queue-based model
// tracks the expected head result for all three.
module tb_bsg_bitwise_reduce_pipe;

   logic         clk;
   logic         rst;
   logic         v, yumi;
   logic [2:0]   op;
   logic [127:0] data;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [15:0] r1;
      logic [15:0] r3;
      logic [15:0] r8;
   } ent_t;

   ent_t q[$];

   bsg_bitwise_reduce_pipe_if #(.width_p(16), .els_p(1)) io1 ();
   bsg_bitwise_reduce_pipe_if #(.width_p(16), .els_p(3)) io3 ();
   bsg_bitwise_reduce_pipe_if #(.width_p(16), .els_p(8)) io8 ();

   assign io1.v_i = v;  assign io1.yumi_i = yumi;  assign io1.op_i = op;  assign io1.data_i = data[15:0];
   assign io3.v_i = v;  assign io3.yumi_i = yumi;  assign io3.op_i = op;  assign io3.data_i = data[47:0];
   assign io8.v_i = v;  assign io8.yumi_i = yumi;  assign io8.op_i = op;  assign io8.data_i = data;

   bsg_bitwise_reduce_pipe #(.width_p(16), .els_p(1)) dut1 (.clk_i(clk), .reset_i(rst), .io(io1));
   bsg_bitwise_reduce_pipe #(.width_p(16), .els_p(3)) dut3 (.clk_i(clk), .reset_i(rst), .io(io3));
   bsg_bitwise_reduce_pipe #(.width_p(16), .els_p(8)) dut8 (.clk_i(clk), .reset_i(rst), .io(io8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: count ones per bit position and apply the op's rule.
   function automatic logic [15:0] ref_red(input logic [2:0] o, input logic [127:0] d, input int n);
      logic [15:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) begin
         int c;
         logic one;
         c = 0;
         for (int k = 0; k < n; k++) if (d[k*16+b]) c++;
         case (o)
            3'd0:    one = (c > 0);
            3'd2:    one = (c == n);
            3'd3:    one = (c != n);
            3'd4:    one = (c % 2 == 1);
            3'd5:    one = (c % 2 == 0);
            default: one = (c == 0);
         endcase
         r[b] = one;
      end
      return r;
   endfunction

   task automatic check_outputs();
      ent_t e;
      logic expv, expr;
      expv = (q.size() > 0);
      expr = (q.size() < 2);
      chk("v_o_e1",  32'(io1.v_o), 32'(expv));
      chk("v_o_e3",  32'(io3.v_o), 32'(expv));
      chk("v_o_e8",  32'(io8.v_o), 32'(expv));
      chk("ready_e1", 32'(io1.ready_o), 32'(expr));
      chk("ready_e3", 32'(io3.ready_o), 32'(expr));
      chk("ready_e8", 32'(io8.ready_o), 32'(expr));
      if (expv) begin
         e = q[0];
         chk("data_e1", 32'(io1.data_o), 32'(e.r1));
         chk("data_e3", 32'(io3.data_o), 32'(e.r3));
         chk("data_e8", 32'(io8.data_o), 32'(e.r8));
      end
   endtask

   // One clock: drive, model the edge, check at the falling edge.
   task automatic cycle(input logic vv, input logic [2:0] oo, input logic [127:0] dd, input logic yy);
      logic acc, pp;
      ent_t e;
      v    = vv;
      op   = oo;
      data = dd;
      yumi = yy && (q.size() > 0);
      acc  = vv && (q.size() < 2);
      pp   = yumi;
      e.r1 = ref_red(oo, dd, 1);
      e.r3 = ref_red(oo, dd, 3);
      e.r8 = ref_red(oo, dd, 8);
      @(posedge clk);
      #1;
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(e);
      @(negedge clk);
      check_outputs();
   endtask

   function automatic logic [127:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst = 1'b1; v = 1'b0; yumi = 1'b0; op = 3'd0; data = '0;
      #23;
      chk("rst_v_o",   32'(io3.v_o), 32'd0);
      chk("rst_ready", 32'(io3.ready_o), 32'd0);
      chk("rst_data",  32'(io3.data_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(io3.ready_o), 32'd1);
      @(negedge clk);
      check_outputs();

      // 3-input NOR, single set bit
      cycle(1'b1, 3'd1, 128'h0001_0000_0000, 1'b0);
      chk("nor3_const", 32'(io3.data_o), 32'h0000_FFFE);
      cycle(1'b0, 3'd0, '0, 1'b1);

      // XOR, then AND on same operands with simultaneous accept and pop
      cycle(1'b1, 3'd4, 128'h3333_0F0F_00FF, 1'b0);
      chk("xor3_const", 32'(io3.data_o), 32'h0000_3CC3);
      cycle(1'b1, 3'd2, 128'h3333_0F0F_00FF, 1'b1);
      chk("and3_const", 32'(io3.data_o), 32'h0000_0003);
      chk("occ_stays1", 32'(io3.ready_o), 32'd1);
      cycle(1'b0, 3'd0, '0, 1'b1);

      // Fill to two entries, third request stalls, then drain in order
      for (int i = 0; i < 3; i++) cycle(1'b1, 3'(i), rnd_data(), 1'b0);
      chk("full_ready", 32'(io3.ready_o), 32'd0);
      cycle(1'b0, 3'd0, '0, 1'b1);
      cycle(1'b0, 3'd0, '0, 1'b1);
      chk("drained_ready", 32'(io3.ready_o), 32'd1);

      // Reset mid-cycle with two entries buffered
      cycle(1'b1, 3'd5, rnd_data(), 1'b0);
      cycle(1'b1, 3'd0, rnd_data(), 1'b0);
      v = 1'b0; yumi = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_v_o",   32'(io3.v_o), 32'd0);
      chk("midrst_ready", 32'(io3.ready_o), 32'd0);
      chk("midrst_data",  32'(io3.data_o), 32'd0);
      chk("midrst_v_o8",  32'(io8.v_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      #1;
      chk("rel_ready", 32'(io3.ready_o), 32'd1);
      chk("rel_v_o",   32'(io3.v_o), 32'd0);
      @(negedge clk);
      cycle(1'b0, 3'd0, '0, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 10000; i++)
         cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_data(),
               $urandom_range(0, 2) != 0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, '0, 1'b1);
      chk("final_empty", 32'(io3.v_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
